// File: rtl/uart_spi_bridge_if.sv
// Byte-level handshake bundle between the frame bridge, the UART controller
// and the SPI master.
//   rx_data/rx_valid        : received UART byte and its one-cycle strobe
//   tx_data/tx_start        : byte and one-cycle request towards UART TX
//   tx_ready                : UART TX idle
//   spi_tx_data/spi_start   : MOSI byte and one-cycle transfer request
//   spi_rx_data/spi_done    : MISO byte and one-cycle completion strobe
// master = bridge side, slave = UART/SPI side.
interface uart_spi_bridge_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready;
  logic [7:0] spi_tx_data;
  logic       spi_start;
  logic [7:0] spi_rx_data;
  logic       spi_done;

  modport master (
    input  rx_data, rx_valid, tx_ready, spi_rx_data, spi_done,
    output tx_data, tx_start, spi_tx_data, spi_start
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, spi_rx_data, spi_done,
    input  tx_data, tx_start, spi_tx_data, spi_start
  );
endinterface

// File: rtl/uart_spi_bridge.sv
// Framed UART-to-SPI command bridge.
// Collects a request frame (SOF_REQ, LEN, payload, XOR checksum) from the
// UART RX stream, runs one SPI transfer per payload byte and returns the
// MISO bytes as a response frame (SOF_RSP, LEN, data, XOR checksum).
// Ports:
//   clk, reset          : system clock, asynchronous active-high reset
//   bus                 : uart_spi_bridge_if.master handshake bundle
//   busy                : high whenever the frame engine is not hunting
//   frame_err_count     : saturating count of rejected frames
//   overrun             : sticky, a byte arrived outside a receive state
module uart_spi_bridge #(
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 5000000,
  parameter logic [7:0] SOF_REQ        = 8'hA5,
  parameter logic [7:0] SOF_RSP        = 8'h5A
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_spi_bridge_if.master      bus,
  output logic                   busy,
  output logic [7:0]             frame_err_count,
  output logic                   overrun
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DEPTH = 1 << IDX_W;
  localparam int GAP_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [7:0]       LEN_MAX  = 8'(MAX_LEN);

  typedef enum logic [3:0] {
    S_HUNT      = 4'd0,
    S_LEN       = 4'd1,
    S_PAYLOAD   = 4'd2,
    S_CHK       = 4'd3,
    S_SPI_ISSUE = 4'd4,
    S_SPI_WAIT  = 4'd5,
    S_TX_SEND   = 4'd6,
    S_TX_WAIT   = 4'd7
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       rsp_chk_q, rsp_chk_d;
  logic [8:0]       ptr_q, ptr_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       err_q, err_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic             first_q, first_d;
  logic             spi_start_q, spi_start_d;
  logic [7:0]       spi_tx_data_q, spi_tx_data_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [7:0]       payload_q [DEPTH];
  logic [7:0]       payload_d [DEPTH];
  logic [7:0]       resp_q [DEPTH];
  logic [7:0]       resp_d [DEPTH];

  logic             tx_start_s;
  logic             err_inc_s;
  logic             rx_state_s;
  logic             timeout_s;
  logic [7:0]       idx_nxt_s;
  logic [8:0]       ptr_nxt_s;
  logic [IDX_W-1:0] rsp_idx_s;
  logic [7:0]       nxt_tx_byte_s;

  assign bus.spi_start   = spi_start_q;
  assign bus.spi_tx_data = spi_tx_data_q;
  assign bus.tx_data     = tx_data_q;
  // tx_start is decoded from the registered state so it can fire in the
  // same cycle tx_ready is seen; tx_data is already registered by then.
  assign bus.tx_start    = tx_start_s;
  assign busy            = busy_q;
  assign frame_err_count = err_q;
  assign overrun         = overrun_q;

  // Response byte that follows the current pointer: LEN, MISO data, then CHK.
  always_comb begin
    ptr_nxt_s = ptr_q + 9'd1;
    rsp_idx_s = IDX_W'(ptr_q - 9'd1);
    if (ptr_nxt_s == 9'd1) begin
      nxt_tx_byte_s = len_q;
    end else if (ptr_nxt_s <= ({1'b0, len_q} + 9'd1)) begin
      nxt_tx_byte_s = resp_q[rsp_idx_s];
    end else begin
      nxt_tx_byte_s = rsp_chk_q;
    end
  end

  // Frame engine: next-state and datapath updates.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    rsp_chk_d     = rsp_chk_q;
    ptr_d         = ptr_q;
    first_d       = first_q;
    spi_start_d   = 1'b0;
    spi_tx_data_d = spi_tx_data_q;
    tx_data_d     = tx_data_q;
    payload_d     = payload_q;
    resp_d        = resp_q;
    tx_start_s    = 1'b0;
    err_inc_s     = 1'b0;
    idx_nxt_s     = idx_q + 8'd1;

    rx_state_s = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
    // A byte on the timeout cycle wins: timeout only fires without rx_valid.
    timeout_s  = rx_state_s && !bus.rx_valid && (gap_q == GAP_LAST);

    if (rx_state_s && !bus.rx_valid && !timeout_s) begin
      gap_d = gap_q + GAP_ONE;
    end else begin
      gap_d = GAP_ZERO;
    end

    case (state_q)
      S_HUNT: begin
        if (bus.rx_valid && (bus.rx_data == SOF_REQ)) begin
          state_d = S_LEN;
        end else begin
          state_d = S_HUNT;
        end
      end
      S_LEN: begin
        if (bus.rx_valid) begin
          len_d = bus.rx_data;
          acc_d = bus.rx_data;
          idx_d = 8'd0;
          if ((bus.rx_data == 8'd0) || (bus.rx_data > LEN_MAX)) begin
            err_inc_s = 1'b1;
            state_d   = S_HUNT;
          end else begin
            state_d = S_PAYLOAD;
          end
        end else if (timeout_s) begin
          err_inc_s = 1'b1;
          state_d   = S_HUNT;
        end else begin
          state_d = S_LEN;
        end
      end
      S_PAYLOAD: begin
        if (bus.rx_valid) begin
          payload_d[idx_q[IDX_W-1:0]] = bus.rx_data;
          acc_d = acc_q ^ bus.rx_data;
          idx_d = idx_nxt_s;
          if (idx_nxt_s == len_q) begin
            state_d = S_CHK;
          end else begin
            state_d = S_PAYLOAD;
          end
        end else if (timeout_s) begin
          err_inc_s = 1'b1;
          state_d   = S_HUNT;
        end else begin
          state_d = S_PAYLOAD;
        end
      end
      S_CHK: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == acc_q) begin
            // Launch the first transfer straight away so spi_start is high
            // in the cycle right after the checksum byte.
            idx_d         = 8'd0;
            rsp_chk_d     = len_q;
            spi_start_d   = 1'b1;
            spi_tx_data_d = payload_q[0];
            state_d       = S_SPI_ISSUE;
          end else begin
            err_inc_s = 1'b1;
            state_d   = S_HUNT;
          end
        end else if (timeout_s) begin
          err_inc_s = 1'b1;
          state_d   = S_HUNT;
        end else begin
          state_d = S_CHK;
        end
      end
      S_SPI_ISSUE: begin
        state_d = S_SPI_WAIT;
      end
      S_SPI_WAIT: begin
        if (bus.spi_done) begin
          resp_d[idx_q[IDX_W-1:0]] = bus.spi_rx_data;
          rsp_chk_d = rsp_chk_q ^ bus.spi_rx_data;
          idx_d     = idx_nxt_s;
          if (idx_nxt_s == len_q) begin
            ptr_d     = 9'd0;
            tx_data_d = SOF_RSP;
            state_d   = S_TX_SEND;
          end else begin
            spi_start_d   = 1'b1;
            spi_tx_data_d = payload_q[idx_nxt_s[IDX_W-1:0]];
            state_d       = S_SPI_ISSUE;
          end
        end else begin
          state_d = S_SPI_WAIT;
        end
      end
      S_TX_SEND: begin
        if (bus.tx_ready) begin
          tx_start_s = 1'b1;
          first_d    = 1'b1;
          state_d    = S_TX_WAIT;
        end else begin
          state_d = S_TX_SEND;
        end
      end
      S_TX_WAIT: begin
        // tx_ready may still read high on the cycle after tx_start.
        if (first_q) begin
          first_d = 1'b0;
          state_d = S_TX_WAIT;
        end else if (bus.tx_ready) begin
          if (ptr_q == ({1'b0, len_q} + 9'd2)) begin
            state_d = S_HUNT;
          end else begin
            ptr_d     = ptr_nxt_s;
            tx_data_d = nxt_tx_byte_s;
            state_d   = S_TX_SEND;
          end
        end else begin
          state_d = S_TX_WAIT;
        end
      end
      default: begin
        state_d = S_HUNT;
      end
    endcase

    if (bus.rx_valid && (state_q inside {S_SPI_ISSUE, S_SPI_WAIT, S_TX_SEND, S_TX_WAIT})) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    if (err_inc_s && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end else begin
      err_d = err_q;
    end

    busy_d = (state_d != S_HUNT);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_HUNT;
      len_q         <= 8'd0;
      idx_q         <= 8'd0;
      acc_q         <= 8'd0;
      rsp_chk_q     <= 8'd0;
      ptr_q         <= 9'd0;
      gap_q         <= GAP_ZERO;
      err_q         <= 8'd0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
      first_q       <= 1'b0;
      spi_start_q   <= 1'b0;
      spi_tx_data_q <= 8'd0;
      tx_data_q     <= 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
        payload_q[i] <= 8'd0;
        resp_q[i]    <= 8'd0;
      end
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      rsp_chk_q     <= rsp_chk_d;
      ptr_q         <= ptr_d;
      gap_q         <= gap_d;
      err_q         <= err_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
      first_q       <= first_d;
      spi_start_q   <= spi_start_d;
      spi_tx_data_q <= spi_tx_data_d;
      tx_data_q     <= tx_data_d;
      payload_q     <= payload_d;
      resp_q        <= resp_d;
    end
  end

endmodule

// File: doc/uart_spi_bridge.md
Name: uart_spi_bridge

Overview:
Framed command bridge between the UART controller and the SPI master in the FPGA-to-Arduino link. It replaces the direct byte-forwarding glue between them. It collects a checksummed request frame from the UART RX byte stream and issues one SPI transfer per payload byte, strictly sequenced. It then returns the captured MISO bytes to the host as a checksummed response frame through the UART TX handshake.

Parameters:
MAX_LEN, 16, maximum payload bytes per frame (1..255); sizes the payload/response buffers
TIMEOUT_CYCLES, 5000000, inter-byte gap limit during request reception (100 ms at 50 MHz)
SOF_REQ, 8'hA5, request start-of-frame byte
SOF_RSP, 8'h5A, response start-of-frame byte

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
rx_data  in  8  byte from UART RX, valid when rx_valid=1
rx_valid  in  1  single-cycle strobe per received byte
tx_data  out  8  byte to UART TX, held stable from tx_start until tx_ready returns high
tx_start  out  1  single-cycle request to UART TX
tx_ready  in  1  UART TX idle; drops the cycle after an accepted tx_start
spi_tx_data  out  8  byte to SPI master, held stable through the transfer
spi_start  out  1  single-cycle transfer request to SPI master
spi_rx_data  in  8  MISO byte, valid when spi_done=1
spi_done  in  1  single-cycle transfer-complete strobe
busy  out  1  high in every state except HUNT
frame_err_count  out  8  saturating count of rejected frames
overrun  out  1  sticky flag: a byte arrived while the block was not in a receive state

Behaviour:
- Reset is clk asynchronous, active-high. Reset values: all outputs 0, state HUNT, counters 0.
- Reset mid-operation aborts immediately. A partial frame is discarded and no response is sent.
- Request frame: SOF_REQ, LEN, LEN payload bytes, CHK. CHK = XOR of LEN and all payload bytes.
- Response frame: SOF_RSP, LEN, LEN MISO bytes, CHK. CHK = XOR of LEN and all MISO bytes.
- States:
  - HUNT: on rx_valid with rx_data==SOF_REQ, go to LEN. Any other byte is dropped silently.
  - LEN: on rx_valid, latch LEN and seed the checksum accumulator with LEN. If LEN==0 or LEN>MAX_LEN: increment the error count and go to HUNT. Otherwise clear the index and go to PAYLOAD.
  - PAYLOAD: store each byte at buffer[index], XOR it into the accumulator, increment index. Go to CHK after byte LEN.
  - CHK: on rx_valid, compare against the accumulator. Match: go to SPI_ISSUE with index=0. Mismatch: increment the error count and go to HUNT.
  - SPI_ISSUE: drive spi_tx_data=buffer[index] and pulse spi_start for one cycle, then go to SPI_WAIT.
  - SPI_WAIT: on spi_done, write spi_rx_data into resp[index] and increment index. If index reaches LEN, go to TX_SEND with tx pointer=0. Otherwise return to SPI_ISSUE. The next spi_start is therefore at least one cycle after spi_done, and the SPI master is back in IDLE by then.
  - TX_SEND: when tx_ready=1, drive the current response byte and pulse tx_start, then go to TX_WAIT. Byte order: SOF_RSP, LEN, resp[0..LEN-1], CHK.
  - TX_WAIT: ignore tx_ready for the first cycle, then wait for tx_ready=1. Advance the pointer. After CHK is sent, go to HUNT; otherwise go to TX_SEND.
- Timeout: in LEN, PAYLOAD and CHK, a gap counter reloads on every rx_valid. If the count reaches TIMEOUT_CYCLES, increment the error count and go to HUNT. No timeout applies in SPI or TX states.
- frame_err_count saturates at 255 and is cleared only by reset.
- Overrun: an rx_valid in SPI_ISSUE, SPI_WAIT, TX_SEND or TX_WAIT drops the byte and sets overrun, which is cleared only by reset.
- Simultaneous events: an rx_valid on the same cycle as a timeout is processed as the byte and reloads the counter. The timeout is ignored.
- Spurious strobes: spi_done outside SPI_WAIT is ignored.
- Latency: spi_start is asserted 1 cycle after the CHK byte's rx_valid. The first tx_start follows 1 cycle after the final spi_done, provided tx_ready=1.

Test Plan:
- Good frame: rx bytes A5 02 11 22 31, SPI slave model returns C3 then 3C -> spi_tx_data sequence 11, 22; UART TX emits 5A 02 C3 3C FD; frame_err_count=0.
- Bad checksum: A5 02 11 22 30 -> no spi_start, no tx_start; frame_err_count=1; the following good frame is processed normally.
- Length bounds: A5 00 and A5 11 (with MAX_LEN=16) -> each increments frame_err_count and returns to HUNT; A5 10 with 16 bytes and a correct CHK -> 16 transfers and a 19-byte response.
- Timeout: A5 02 11, then idle for TIMEOUT_CYCLES -> frame_err_count increments, busy=0; a new A5 frame is accepted.
- Overrun and reset: inject rx_valid during SPI_WAIT -> overrun=1 and the response is unaffected; assert reset during TX_SEND -> all outputs 0, state HUNT, overrun=0, no further tx_start.
